// File: rtl/game_countdown.sv
// Round countdown timer: consumes a 1 Hz tick and counts down from START_SECONDS in BCD.
// Supports start/restart and pause/resume, and flags warning, game-over and expiry.
module game_countdown #(
  parameter int unsigned START_SECONDS = 60,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       running,
  output logic       warning,
  output logic       game_over,
  output logic       expired
);

  localparam logic [3:0] StartTens = 4'(START_SECONDS / 10);
  localparam logic [3:0] StartOnes = 4'(START_SECONDS % 10);

  typedef enum logic [1:0] {StIdle, StRunning, StPaused, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       running_q, running_d;
  logic       warning_q, warning_d;
  logic       game_over_q, game_over_d;
  logic       expired_q, expired_d;
  logic [6:0] remaining_d;

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    expired_d = 1'b0;

    // start outranks tick and pause in every state
    if (start) begin
      tens_d  = StartTens;
      ones_d  = StartOnes;
      state_d = StRunning;
    end else begin
      unique case (state_q)
        StRunning: begin
          if (tick_in) begin
            if (tens_q == 4'd0 && ones_q <= 4'd1) begin
              tens_d    = 4'd0;
              ones_d    = 4'd0;
              state_d   = StDone;
              expired_d = 1'b1;
            end else begin
              if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end else begin
                ones_d = ones_q - 4'd1;
              end
              if (pause) state_d = StPaused;
            end
          end else if (pause) begin
            state_d = StPaused;
          end
        end
        StPaused: begin
          if (pause) state_d = StRunning;
        end
        default: ;
      endcase
    end

    remaining_d = 7'(tens_d) * 7'd10 + 7'(ones_d);
    running_d   = (state_d == StRunning);
    game_over_d = (state_d == StDone);
    warning_d   = (state_d == StRunning || state_d == StPaused) &&
                  (32'(remaining_d) <= WARN_SECONDS);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tens_q      <= StartTens;
      ones_q      <= StartOnes;
      running_q   <= 1'b0;
      warning_q   <= 1'b0;
      game_over_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      running_q   <= running_d;
      warning_q   <= warning_d;
      game_over_q <= game_over_d;
      expired_q   <= expired_d;
    end
  end

  assign time_tens = tens_q;
  assign time_ones = ones_q;
  assign running   = running_q;
  assign warning   = warning_q;
  assign game_over = game_over_q;
  assign expired   = expired_q;

endmodule
